// File: rtl/data_bus_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module   : data_bus_bridge_pkg
// Brief    : Shared types and constants for the MEM-stage data bus bridge.
//            Holds the bridge state encoding, the word transfer size, and
//            the memory opcode values used by the MEM-stage units.
// Revision : 1.0  initial release
// ============================================================================
package data_bus_bridge_pkg;

   // Bridge transaction states (3-bit encoding)
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_REQ    = 3'd1,
      ST_WAIT   = 3'd2,
      ST_DONE   = 3'd3,
      ST_CANCEL = 3'd4
   } bus_state_t;

   // Every bus transfer is a full word; byte lanes are selected by wstrb
   localparam logic [1:0] SIZE_WORD = 2'b10;

   // Memory-access opcodes (primary opcode field)
   localparam logic [5:0] OP_LB  = 6'h20;
   localparam logic [5:0] OP_LH  = 6'h21;
   localparam logic [5:0] OP_LW  = 6'h23;
   localparam logic [5:0] OP_LBU = 6'h24;
   localparam logic [5:0] OP_LHU = 6'h25;
   localparam logic [5:0] OP_SB  = 6'h28;
   localparam logic [5:0] OP_SH  = 6'h29;
   localparam logic [5:0] OP_SW  = 6'h2b;

   // Word-aligned form of a byte address
   function automatic logic [31:0] word_addr(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage
`default_nettype wire

// File: rtl/data_bus_watchdog.sv
`default_nettype none
// ============================================================================
// Module   : data_bus_watchdog
// Brief    : Cycle counter that flags a bus transaction running too long.
//            expire is asserted in the enabled cycle in which the count
//            reaches TIMEOUT_CYCLES (counting that cycle).
// Revision : 1.0  initial release
// ============================================================================
module data_bus_watchdog #(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int CNT_W          = 8
) (
   input  logic clk,
   input  logic resetn,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   logic [CNT_W-1:0] r_cnt;

   // Count busy cycles; a new request restarts the count from zero
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_cnt <= '0;
      end else if (clear) begin
         r_cnt <= '0;
      end else if (enable) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign expire = enable && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule
`default_nettype wire

// File: rtl/data_bus_bridge.sv
`default_nettype none
// ============================================================================
// Module   : data_bus_bridge
// Brief    : MEM-stage bridge from the byte-lane select unit to the
//            SRAM-like data bus. One transaction per load/store, pipeline
//            stalled until it completes; raw read word returned on mem_rdata.
//            Optional bus watchdog enabled by defining DATA_BUS_TIMEOUT_EN.
// Revision : 1.0  initial release
// ============================================================================
module data_bus_bridge
   import data_bus_bridge_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int CNT_W          = 8
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        mem_valid,
   input  logic        mem_wen,
   input  logic [3:0]  mem_sel,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   input  logic        mem_excpt,
   input  logic        mem_flush,
   input  logic        wb_allowin,
   output logic        mem_stall,
   output logic [31:0] mem_rdata,
   output logic        bus_err,
   output logic        data_req,
   output logic        data_wr,
   output logic [1:0]  data_size,
   output logic [3:0]  data_wstrb,
   output logic [31:0] data_addr,
   output logic [31:0] data_wdata,
   input  logic        data_addr_ok,
   input  logic        data_data_ok,
   input  logic [31:0] data_rdata
);

   // The watchdog counter must be able to represent TIMEOUT_CYCLES
   if ((64'd1 << CNT_W) <= 64'(TIMEOUT_CYCLES)) begin : g_cfg_check
      $error("data_bus_bridge: 2**CNT_W must exceed TIMEOUT_CYCLES");
   end

   bus_state_t  r_state;
   bus_state_t  w_next;

   logic        r_wr;
   logic [3:0]  r_sel;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [31:0] r_rdata;

   logic        w_accept;      // MEM holds an access that may go to the bus
   logic        w_capture;     // latch request registers this cycle
   logic        w_load_rdata;  // load data arrives this cycle
   logic        w_timeout;     // watchdog forces completion this cycle
   logic        w_expire;

   assign w_accept = mem_valid & ~mem_excpt & ~mem_flush;

   // Next-state decode; flush in WAIT outranks data_ok, watchdog outranks all
   always_comb begin
      w_next       = r_state;
      w_capture    = 1'b0;
      w_load_rdata = 1'b0;
      w_timeout    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_capture = 1'b1;
               w_next    = ST_REQ;
            end
         end
         ST_REQ: begin
            if (w_expire) begin
               w_timeout = 1'b1;
               w_next    = ST_DONE;
            end else if (data_addr_ok) begin
               w_next = mem_flush ? ST_CANCEL : ST_WAIT;
            end else if (mem_flush) begin
               w_next = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (w_expire) begin
               w_timeout = 1'b1;
               w_next    = ST_DONE;
            end else if (mem_flush) begin
               w_next = ST_CANCEL;
            end else if (data_data_ok) begin
               w_load_rdata = ~r_wr;
               w_next       = ST_DONE;
            end
         end
         ST_DONE: begin
            if (wb_allowin | mem_flush) begin
               w_next = ST_IDLE;
            end
         end
         ST_CANCEL: begin
            // The orphaned response retires here; a waiting access may be
            // captured in the same cycle so its request follows immediately.
            if (w_expire) begin
               w_timeout = 1'b1;
               w_next    = ST_DONE;
            end else if (data_data_ok) begin
               if (w_accept) begin
                  w_capture = 1'b1;
                  w_next    = ST_REQ;
               end else begin
                  w_next = ST_IDLE;
               end
            end
         end
         default: begin
            w_next = ST_IDLE;
         end
      endcase
   end

   // Pipeline stall: held while an access is in flight, released on flush
   always_comb begin
      mem_stall = 1'b0;
      case (r_state)
         ST_IDLE:          mem_stall = w_accept;
         ST_REQ, ST_WAIT:  mem_stall = 1'b1;
         ST_CANCEL:        mem_stall = mem_valid;
         default:          mem_stall = 1'b0;
      endcase
      if (mem_flush) begin
         mem_stall = 1'b0;
      end
   end

   // State register
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Request registers; stable from capture until the next capture
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_wr    <= 1'b0;
         r_sel   <= 4'b0000;
         r_addr  <= 32'h0;
         r_wdata <= 32'h0;
      end else if (w_capture) begin
         r_wr    <= mem_wen;
         r_sel   <= mem_sel;
         r_addr  <= word_addr(mem_addr);
         r_wdata <= mem_wdata;
      end
   end

   // Read word register; a watchdog completion returns zero
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_rdata <= 32'h0;
      end else if (w_timeout) begin
         r_rdata <= 32'h0;
      end else if (w_load_rdata) begin
         r_rdata <= data_rdata;
      end
   end

`ifdef DATA_BUS_TIMEOUT_EN
   logic r_bus_err;
   logic w_wd_enable;

   assign w_wd_enable = (r_state == ST_REQ) || (r_state == ST_WAIT) ||
                        (r_state == ST_CANCEL);

   data_bus_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .CNT_W          (CNT_W)
   ) u_watchdog (
      .clk    (clk),
      .resetn (resetn),
      .clear  (w_capture),
      .enable (w_wd_enable),
      .expire (w_expire)
   );

   // Error flag lives exactly as long as the timed-out DONE state
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_bus_err <= 1'b0;
      end else if (w_timeout) begin
         r_bus_err <= 1'b1;
      end else if (w_next != ST_DONE) begin
         r_bus_err <= 1'b0;
      end
   end

   assign bus_err = r_bus_err;
`else
   assign w_expire = 1'b0;
   assign bus_err  = 1'b0;
`endif

   assign data_req   = (r_state == ST_REQ);
   assign data_wr    = r_wr;
   assign data_size  = SIZE_WORD;
   assign data_wstrb = r_sel;
   assign data_addr  = r_addr;
   assign data_wdata = r_wdata;
   assign mem_rdata  = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_data_bus_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_bus_bridge
// Brief    : Self-checking bench for data_bus_bridge. Random addresses, data,
//            strobes and bus latencies checked against a transaction-level
//            reference (word alignment, last loaded word, handshake counts).
// Revision : 1.0  initial release
// ============================================================================
module tb_data_bus_bridge;

   localparam int TB_TIMEOUT = 8;

   logic        clk = 1'b0;
   logic        resetn;
   logic        mem_valid, mem_wen, mem_excpt, mem_flush, wb_allowin;
   logic [3:0]  mem_sel;
   logic [31:0] mem_addr, mem_wdata;
   logic        mem_stall, bus_err;
   logic [31:0] mem_rdata;
   logic        data_req, data_wr;
   logic [1:0]  data_size;
   logic [3:0]  data_wstrb;
   logic [31:0] data_addr, data_wdata;
   logic        data_addr_ok, data_data_ok;
   logic [31:0] data_rdata;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          n_hs    = 0;   // accepted address handshakes
   int          outstanding = 0;
   logic [31:0] model_rdata = 32'h0;  // last word a load returned

   always #5 clk = ~clk;

   data_bus_bridge #(
      .TIMEOUT_CYCLES (TB_TIMEOUT),
      .CNT_W          (8)
   ) dut (
      .clk          (clk),
      .resetn       (resetn),
      .mem_valid    (mem_valid),
      .mem_wen      (mem_wen),
      .mem_sel      (mem_sel),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_excpt    (mem_excpt),
      .mem_flush    (mem_flush),
      .wb_allowin   (wb_allowin),
      .mem_stall    (mem_stall),
      .mem_rdata    (mem_rdata),
      .bus_err      (bus_err),
      .data_req     (data_req),
      .data_wr      (data_wr),
      .data_size    (data_size),
      .data_wstrb   (data_wstrb),
      .data_addr    (data_addr),
      .data_wdata   (data_wdata),
      .data_addr_ok (data_addr_ok),
      .data_data_ok (data_data_ok),
      .data_rdata   (data_rdata)
   );

   // Bus slave bookkeeping: one outstanding transaction, data_ok only after a handshake
   always @(posedge clk) begin
      if (!resetn) begin
         outstanding = 0;
      end else begin
         if (data_data_ok) begin
            n_tests++;
            if (outstanding != 1) begin
               n_fail++;
               $display("FAIL bus_data_ok: outstanding=%0d required 1", outstanding);
            end else begin
               outstanding--;
            end
         end
         if (data_req && data_addr_ok) begin
            n_hs++;
            n_tests++;
            if (outstanding != 0) begin
               n_fail++;
               $display("FAIL bus_one_outstanding: outstanding=%0d required 0", outstanding);
            end
            outstanding++;
         end
      end
   end

   function automatic logic [31:0] word_of(input logic [31:0] a);
      return a - (a % 32'd4);
   endfunction

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #3;
   endtask

   task automatic drive_idle();
      mem_valid    = 1'b0;
      mem_wen      = 1'b0;
      mem_sel      = 4'b0000;
      mem_addr     = 32'h0;
      mem_wdata    = 32'h0;
      mem_excpt    = 1'b0;
      mem_flush    = 1'b0;
      wb_allowin   = 1'b1;
      data_addr_ok = 1'b0;
      data_data_ok = 1'b0;
      data_rdata   = $urandom;
   endtask

   task automatic run_load(input logic [31:0] addr, input logic [31:0] data,
                           input int da, input int dd, input int hold);
      int hs0;
      hs0 = n_hs;
      mem_valid = 1'b1; mem_wen = 1'b0; mem_sel = 4'b0000;
      mem_addr = addr; mem_wdata = $urandom;
      settle();
      n_tests++;
      if ({mem_stall, data_req} !== 2'b10) begin
         n_fail++;
         $display("FAIL load_capture: stall,req=%b required 10", {mem_stall, data_req});
      end
      next_cycle();
      for (int i = 0; i <= da; i++) begin
         data_addr_ok = (i == da);
         settle();
         n_tests++;
         if ({data_req, data_wr, data_wstrb, mem_stall, data_addr} !==
             {1'b1, 1'b0, 4'b0000, 1'b1, word_of(addr)}) begin
            n_fail++;
            $display("FAIL load_req: req,wr,strb,stall=%b addr=%h required 1000001 addr=%h",
                     {data_req, data_wr, data_wstrb, mem_stall}, data_addr, word_of(addr));
         end
         next_cycle();
      end
      data_addr_ok = 1'b0;
      for (int i = 0; i <= dd; i++) begin
         data_data_ok = (i == dd);
         data_rdata   = (i == dd) ? data : $urandom;
         settle();
         n_tests++;
         if ({data_req, mem_stall} !== 2'b01) begin
            n_fail++;
            $display("FAIL load_wait: req,stall=%b required 01", {data_req, mem_stall});
         end
         next_cycle();
      end
      data_data_ok = 1'b0;
      data_rdata   = $urandom;
      model_rdata  = data;
      for (int i = 0; i <= hold; i++) begin
         wb_allowin = (i == hold);
         settle();
         n_tests++;
         if ({mem_stall, bus_err, data_req, mem_rdata} !== {3'b000, model_rdata}) begin
            n_fail++;
            $display("FAIL load_done: stall,err,req=%b rdata=%h required 000 rdata=%h",
                     {mem_stall, bus_err, data_req}, mem_rdata, model_rdata);
         end
         next_cycle();
      end
      mem_valid = 1'b0; wb_allowin = 1'b1;
      n_tests++;
      if (n_hs !== hs0 + 1) begin
         n_fail++;
         $display("FAIL load_handshakes: got %0d required %0d", n_hs - hs0, 1);
      end
   endtask

   task automatic run_store(input logic [31:0] addr, input logic [3:0] sel,
                            input logic [31:0] wdata, input int da, input int dd,
                            input int hold);
      int hs0;
      hs0 = n_hs;
      mem_valid = 1'b1; mem_wen = 1'b1; mem_sel = sel;
      mem_addr = addr; mem_wdata = wdata;
      settle();
      n_tests++;
      if ({mem_stall, data_req} !== 2'b10) begin
         n_fail++;
         $display("FAIL store_capture: stall,req=%b required 10", {mem_stall, data_req});
      end
      next_cycle();
      for (int i = 0; i <= da; i++) begin
         // request must come from the captured copy, not the live MEM inputs
         mem_addr = $urandom; mem_wdata = $urandom; mem_sel = 4'($urandom);
         data_addr_ok = (i == da);
         settle();
         n_tests++;
         if ({data_req, data_wr, data_wstrb, mem_stall, data_addr, data_wdata} !==
             {1'b1, 1'b1, sel, 1'b1, word_of(addr), wdata}) begin
            n_fail++;
            $display("FAIL store_req: req,wr,strb,stall=%b addr=%h wdata=%h required %b addr=%h wdata=%h",
                     {data_req, data_wr, data_wstrb, mem_stall}, data_addr, data_wdata,
                     {2'b11, sel, 1'b1}, word_of(addr), wdata);
         end
         next_cycle();
      end
      data_addr_ok = 1'b0;
      for (int i = 0; i <= dd; i++) begin
         data_data_ok = (i == dd);
         data_rdata   = $urandom;
         settle();
         n_tests++;
         if ({data_req, mem_stall} !== 2'b01) begin
            n_fail++;
            $display("FAIL store_wait: req,stall=%b required 01", {data_req, mem_stall});
         end
         next_cycle();
      end
      data_data_ok = 1'b0;
      for (int i = 0; i <= hold; i++) begin
         wb_allowin = (i == hold);
         settle();
         n_tests++;
         if ({mem_stall, bus_err, data_req, mem_rdata} !== {3'b000, model_rdata}) begin
            n_fail++;
            $display("FAIL store_done: stall,err,req=%b rdata=%h required 000 rdata=%h",
                     {mem_stall, bus_err, data_req}, mem_rdata, model_rdata);
         end
         next_cycle();
      end
      mem_valid = 1'b0; mem_wen = 1'b0; wb_allowin = 1'b1;
      n_tests++;
      if (n_hs !== hs0 + 1) begin
         n_fail++;
         $display("FAIL store_handshakes: got %0d required %0d", n_hs - hs0, 1);
      end
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      drive_idle();
      #12;
      n_tests++;
      if ({data_req, data_wr, data_wstrb, data_addr, data_wdata} !== 70'h0) begin
         n_fail++;
         $display("FAIL reset_bus: req,wr,strb=%b addr=%h wdata=%h required all zero",
                  {data_req, data_wr, data_wstrb}, data_addr, data_wdata);
      end
      n_tests++;
      if ({mem_rdata, bus_err, mem_stall} !== 34'h0) begin
         n_fail++;
         $display("FAIL reset_mem: rdata=%h err=%b stall=%b required 0", mem_rdata, bus_err, mem_stall);
      end
      n_tests++;
      if (data_size !== 2'b10) begin
         n_fail++;
         $display("FAIL reset_size: size=%b required 10", data_size);
      end
      @(posedge clk);
      #2 resetn = 1'b1;
      next_cycle();
   endtask

   task automatic test_load_min();
      run_load(32'h1000_0006, 32'hAABB_CCDD, 0, 0, 0);
   endtask

   task automatic test_back_to_back();
      for (int n = 0; n < 8; n++) begin
         if ($urandom_range(1, 0) == 1)
            run_load($urandom, $urandom, int'($urandom_range(2, 0)),
                     int'($urandom_range(2, 0)), int'($urandom_range(2, 0)));
         else
            run_store($urandom, 4'($urandom_range(15, 1)), $urandom,
                      int'($urandom_range(2, 0)), int'($urandom_range(2, 0)),
                      int'($urandom_range(2, 0)));
      end
   endtask

   task automatic test_store_delayed();
      run_store(32'h2000_0013, 4'b0100, 32'h5A5A_5A5A, 3, 0, 1);
   endtask

   task automatic test_excpt();
      mem_valid = 1'b1; mem_excpt = 1'b1; mem_addr = $urandom;
      for (int i = 0; i < 4; i++) begin
         settle();
         n_tests++;
         if ({data_req, mem_stall} !== 2'b00) begin
            n_fail++;
            $display("FAIL excpt_suppress: req,stall=%b required 00", {data_req, mem_stall});
         end
         next_cycle();
      end
      mem_excpt = 1'b0;
      run_load($urandom, $urandom, 0, 1, 0);
   endtask

   task automatic test_flush_req();
      int hs0;
      hs0 = n_hs;
      mem_valid = 1'b1; mem_wen = 1'b0; mem_addr = $urandom;
      next_cycle();
      mem_flush = 1'b1;
      settle();
      n_tests++;
      if (mem_stall !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_req_stall: stall=%b required 0", mem_stall);
      end
      next_cycle();
      mem_flush = 1'b0; mem_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         settle();
         n_tests++;
         if ({data_req, mem_stall} !== 2'b00) begin
            n_fail++;
            $display("FAIL flush_req_drop: req,stall=%b required 00", {data_req, mem_stall});
         end
         next_cycle();
      end
      n_tests++;
      if (n_hs !== hs0) begin
         n_fail++;
         $display("FAIL flush_req_handshakes: got %0d required 0", n_hs - hs0);
      end
      run_load($urandom, $urandom, 1, 0, 0);
   endtask

   task automatic test_flush_wait();
      logic [31:0] addr_b, data_b;
      int          k;
      addr_b = $urandom; data_b = $urandom;
      k = int'($urandom_range(3, 1));
      mem_valid = 1'b1; mem_wen = 1'b0; mem_addr = $urandom;
      next_cycle();
      data_addr_ok = 1'b1;
      next_cycle();
      data_addr_ok = 1'b0; mem_flush = 1'b1;
      settle();
      n_tests++;
      if (mem_stall !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_wait_stall: stall=%b required 0", mem_stall);
      end
      next_cycle();
      mem_flush = 1'b0; mem_addr = addr_b;
      for (int i = 0; i <= k; i++) begin
         data_data_ok = (i == k);
         data_rdata   = $urandom;
         settle();
         n_tests++;
         if ({data_req, mem_stall} !== 2'b01) begin
            n_fail++;
            $display("FAIL cancel_hold: req,stall=%b required 01", {data_req, mem_stall});
         end
         next_cycle();
      end
      data_data_ok = 1'b0;
      data_addr_ok = 1'b1;
      settle();
      n_tests++;
      if ({data_req, data_addr} !== {1'b1, word_of(addr_b)}) begin
         n_fail++;
         $display("FAIL cancel_next_req: req=%b addr=%h required 1 addr=%h",
                  data_req, data_addr, word_of(addr_b));
      end
      next_cycle();
      data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = data_b;
      next_cycle();
      data_data_ok = 1'b0; model_rdata = data_b;
      settle();
      n_tests++;
      if ({mem_stall, mem_rdata} !== {1'b0, model_rdata}) begin
         n_fail++;
         $display("FAIL cancel_next_data: stall=%b rdata=%h required 0 rdata=%h",
                  mem_stall, mem_rdata, model_rdata);
      end
      next_cycle();
      mem_valid = 1'b0;
      next_cycle();
   endtask

   task automatic test_reset_mid();
      mem_valid = 1'b1; mem_wen = 1'b1; mem_sel = 4'b1111;
      mem_addr = $urandom | 32'h4; mem_wdata = $urandom | 32'h1;
      next_cycle();
      data_addr_ok = 1'b1;
      next_cycle();
      data_addr_ok = 1'b0; mem_valid = 1'b0; mem_wen = 1'b0;
      settle();
      resetn = 1'b0;
      #1;
      model_rdata = 32'h0;
      n_tests++;
      if ({data_req, data_wr, data_wstrb, data_addr, data_wdata, mem_rdata, mem_stall} !==
          {6'b0, 64'h0, model_rdata, 1'b0}) begin
         n_fail++;
         $display("FAIL reset_mid: req,wr,strb=%b addr=%h wdata=%h rdata=%h stall=%b required all zero",
                  {data_req, data_wr, data_wstrb}, data_addr, data_wdata, mem_rdata, mem_stall);
      end
      @(posedge clk);
      #2 resetn = 1'b1;
      next_cycle();
      settle();
      n_tests++;
      if ({data_req, mem_stall} !== 2'b00) begin
         n_fail++;
         $display("FAIL reset_mid_idle: req,stall=%b required 00", {data_req, mem_stall});
      end
      next_cycle();
      run_load($urandom, $urandom, 0, 0, 0);
   endtask

`ifdef DATA_BUS_TIMEOUT_EN
   task automatic test_timeout();
      mem_valid = 1'b1; mem_wen = 1'b0; mem_addr = $urandom;
      next_cycle();
      for (int i = 0; i < TB_TIMEOUT; i++) begin
         settle();
         n_tests++;
         if ({data_req, bus_err, mem_stall} !== 3'b101) begin
            n_fail++;
            $display("FAIL timeout_req: cycle %0d req,err,stall=%b required 101",
                     i, {data_req, bus_err, mem_stall});
         end
         next_cycle();
      end
      model_rdata = 32'h0;
      settle();
      n_tests++;
      if ({data_req, bus_err, mem_stall, mem_rdata} !== {3'b010, model_rdata}) begin
         n_fail++;
         $display("FAIL timeout_done: req,err,stall=%b rdata=%h required 010 rdata=0",
                  {data_req, bus_err, mem_stall}, mem_rdata);
      end
      next_cycle();
      mem_valid = 1'b0;
      settle();
      n_tests++;
      if ({data_req, bus_err, mem_stall} !== 3'b000) begin
         n_fail++;
         $display("FAIL timeout_clear: req,err,stall=%b required 000",
                  {data_req, bus_err, mem_stall});
      end
      next_cycle();
   endtask
`endif

   initial begin
      test_reset();
      test_load_min();
      test_back_to_back();
      test_store_delayed();
      test_excpt();
      test_flush_req();
      test_flush_wait();
      test_reset_mid();
`ifdef DATA_BUS_TIMEOUT_EN
      test_timeout();
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL sim_time_limit: run did not finish, required completion");
      $fatal(1, "time limit");
   end

endmodule
`default_nettype wire
